// File: rtl/itm_trace_arbiter.sv
// Merges per-core compressed trace streams onto one ready/valid link via per-port FIFOs and round-robin arbitration.
// Optional: define ITM_TRACE_ARBITER_OVERFLOW_MSG_EN to inject drop-count marker messages into the stream.

module itm_trace_fifo #(
    parameter int W     = 72,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic [W-1:0] wdata,
    input  logic         pop,
    output logic [W-1:0] head,
    output logic         empty,
    output logic         full
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            count <= count + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= wdata;
    end

    assign head  = mem[rd_ptr];
    assign empty = (count == '0);
    assign full  = (count == (AW+1)'(DEPTH));
endmodule

module itm_trace_arbiter #(
    parameter int NUM_PORTS  = 4,
    parameter int TS_WIDTH   = 32,
    parameter int CNT_WIDTH  = 8,
    parameter int MSG_WIDTH  = TS_WIDTH + 32 + CNT_WIDTH,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [NUM_PORTS-1:0]           port_enable,
    input  logic [NUM_PORTS*MSG_WIDTH-1:0] trace_in,
    input  logic [NUM_PORTS-1:0]           trace_in_valid,
    output logic [MSG_WIDTH-1:0]           trace_out,
    output logic [3:0]                     trace_out_port,
    output logic                           trace_out_valid,
    input  logic                           trace_out_ready,
    output logic [NUM_PORTS*8-1:0]         drop_cnt,
    output logic [NUM_PORTS-1:0]           fifo_full
);
    localparam int PW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

    typedef enum logic {IDLE, SEND} state_t;

    state_t                              state, state_nxt;
    logic [NUM_PORTS-1:0][MSG_WIDTH-1:0] head, wdata;
    logic [NUM_PORTS-1:0]                empty, full, push, pop, in_hit, drop;
    logic [NUM_PORTS-1:0][7:0]           dcnt;
    logic [PW-1:0]                       rr_ptr, win;
    logic                                any, load;

`ifdef ITM_TRACE_ARBITER_OVERFLOW_MSG_EN
    logic [NUM_PORTS-1:0] mark;

    function automatic logic [CNT_WIDTH-1:0] marker_cnt(input logic [7:0] c);
        logic [31:0] lim;
        lim = (CNT_WIDTH >= 31) ? 32'hffff_ffff : ((32'd1 << CNT_WIDTH) - 32'd1);
        return ({24'd0, c} > lim) ? '1 : CNT_WIDTH'(c);
    endfunction
`endif

    assign load            = (state == IDLE) || trace_out_ready;
    assign trace_out_valid = (state == SEND);
    assign drop_cnt        = dcnt;
    assign fifo_full       = full;

    // Scan from the farthest offset down so the closest non-empty port at/after rr_ptr wins.
    always_comb begin : rr_pick
        logic [PW:0] sum;
        any = 1'b0;
        win = '0;
        sum = '0;
        for (int i = NUM_PORTS - 1; i >= 0; i--) begin
            sum = {1'b0, rr_ptr} + (PW+1)'(i);
            if (sum >= (PW+1)'(NUM_PORTS)) sum = sum - (PW+1)'(NUM_PORTS);
            if (!empty[sum[PW-1:0]]) begin
                any = 1'b1;
                win = sum[PW-1:0];
            end
        end
    end

    for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
        assign in_hit[p] = trace_in_valid[p] && port_enable[p];
        assign pop[p]    = load && any && (win == PW'(p));
        // A same-cycle pop frees the slot, so a push into a full FIFO is not a drop then.
        assign drop[p]   = in_hit[p] && full[p] && !pop[p];

`ifdef ITM_TRACE_ARBITER_OVERFLOW_MSG_EN
        assign mark[p]  = !in_hit[p] && !full[p] && (dcnt[p] != 8'd0);
        assign push[p]  = (in_hit[p] && !drop[p]) || mark[p];
        assign wdata[p] = in_hit[p] ? trace_in[p*MSG_WIDTH +: MSG_WIDTH]
                                    : {{(TS_WIDTH+32){1'b0}}, marker_cnt(dcnt[p])};
`else
        assign push[p]  = in_hit[p] && !drop[p];
        assign wdata[p] = trace_in[p*MSG_WIDTH +: MSG_WIDTH];
`endif

        itm_trace_fifo #(.W(MSG_WIDTH), .DEPTH(FIFO_DEPTH)) u_fifo (
            .clk   (clk),
            .rst_n (rst_n),
            .push  (push[p]),
            .wdata (wdata[p]),
            .pop   (pop[p]),
            .head  (head[p]),
            .empty (empty[p]),
            .full  (full[p])
        );

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n)
                dcnt[p] <= 8'd0;
`ifdef ITM_TRACE_ARBITER_OVERFLOW_MSG_EN
            else if (mark[p])
                dcnt[p] <= drop[p] ? 8'd1 : 8'd0;
`endif
            else if (drop[p] && dcnt[p] != 8'hff)
                dcnt[p] <= dcnt[p] + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            trace_out      <= '0;
            trace_out_port <= '0;
            rr_ptr         <= '0;
        end else begin
            state <= state_nxt;
            if (load && any) begin
                trace_out      <= head[win];
                trace_out_port <= 4'(win);
                rr_ptr         <= (win == PW'(NUM_PORTS - 1)) ? '0 : win + PW'(1);
            end
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (any) state_nxt = SEND;
            SEND:    if (trace_out_ready) state_nxt = any ? SEND : IDLE;
            default: state_nxt = IDLE;
        endcase
    end
endmodule

// File: tb/tb_itm_trace_arbiter.sv
// Scoreboard bench for itm_trace_arbiter: expected messages queued at drive time, matched per port at output.
// Marker checks are compiled in when ITM_TRACE_ARBITER_OVERFLOW_MSG_EN is defined.

module tb_itm_trace_arbiter;
    localparam int NP = 4;
    localparam int MW = 72;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [NP-1:0]    port_enable;
    logic [NP*MW-1:0] trace_in;
    logic [NP-1:0]    trace_in_valid;
    logic [MW-1:0]    trace_out;
    logic [3:0]       trace_out_port;
    logic             trace_out_valid;
    logic             trace_out_ready;
    logic [NP*8-1:0]  drop_cnt;
    logic [NP-1:0]    fifo_full;

    typedef struct {
        logic [3:0]    port;
        logic [MW-1:0] msg;
    } exp_t;

    exp_t       sb[$];
    logic [3:0] port_log[$];
    int         n_cmp = 0;
    int         n_err = 0;

    itm_trace_arbiter #(.NUM_PORTS(NP), .TS_WIDTH(32), .CNT_WIDTH(8), .MSG_WIDTH(MW), .FIFO_DEPTH(4)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .port_enable     (port_enable),
        .trace_in        (trace_in),
        .trace_in_valid  (trace_in_valid),
        .trace_out       (trace_out),
        .trace_out_port  (trace_out_port),
        .trace_out_valid (trace_out_valid),
        .trace_out_ready (trace_out_ready),
        .drop_cnt        (drop_cnt),
        .fifo_full       (fifo_full)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [MW-1:0] mk(input logic [31:0] ts, input logic [31:0] a, input logic [7:0] c);
        return {ts, a, c};
    endfunction

    // Accepted transfers: match against the oldest expected entry of the same port.
    always @(negedge clk) begin
        int k;
        if (rst_n && trace_out_valid && trace_out_ready) begin
            k = -1;
            for (int i = 0; i < sb.size(); i++) begin
                if (sb[i].port == trace_out_port) begin
                    k = i;
                    break;
                end
            end
            port_log.push_back(trace_out_port);
            if (k < 0) chk("sb_unexpected_valid", trace_out_valid, 1'b0);
            else begin
                chk("sb_msg", trace_out, sb[k].msg);
                sb.delete(k);
            end
        end
    end

    task automatic push1(input int p, input logic [MW-1:0] m, input bit acc);
        trace_in[p*MW +: MW] = m;
        trace_in_valid[p]    = 1'b1;
        if (acc) sb.push_back('{4'(p), m});
        @(posedge clk); #1;
        trace_in_valid = '0;
    endtask

    task automatic do_reset();
        rst_n          = 1'b0;
        trace_in_valid = '0;
        sb.delete();
        port_log.delete();
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic drain(input string tag);
        int b;
        b = 0;
        while (sb.size() != 0 && b < 200) begin
            @(negedge clk);
            b++;
        end
        @(negedge clk);
        @(negedge clk);
        chk(tag, sb.size(), 0);
    endtask

    initial begin
        port_enable     = '1;
        trace_in        = '0;
        trace_in_valid  = '0;
        trace_out_ready = 1'b1;
        #12;
        chk("rst_valid", trace_out_valid, 1'b0);
        chk("rst_port",  trace_out_port, 4'd0);
        chk("rst_out",   trace_out, '0);
        chk("rst_drop",  drop_cnt, '0);
        chk("rst_full",  fifo_full, '0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Single push on port 2: one-cycle latency, then idle.
        push1(2, mk(32'h55, 32'h100, 8'd5), 1'b1);
        @(negedge clk); chk("t1_lat_valid0", trace_out_valid, 1'b0);
        @(negedge clk);
        chk("t1_valid", trace_out_valid, 1'b1);
        chk("t1_port",  trace_out_port, 4'd2);
        chk("t1_msg",   trace_out, mk(32'h55, 32'h100, 8'd5));
        @(negedge clk); chk("t1_valid_off", trace_out_valid, 1'b0);
        drain("t1_drain");

        // All four ports at once from rr_ptr=0, then 3 and 0 together.
        do_reset();
        for (int p = 0; p < NP; p++) begin
            trace_in[p*MW +: MW] = mk(32'h200 + p, 32'h1000 + 32'(p) * 16, 8'(p + 1));
            sb.push_back('{4'(p), trace_in[p*MW +: MW]});
        end
        trace_in_valid = '1;
        @(posedge clk); #1;
        trace_in_valid = '0;
        drain("t2_drain_a");
        trace_in[0*MW +: MW] = mk(32'h300, 32'h2000, 8'd9);
        trace_in[3*MW +: MW] = mk(32'h303, 32'h2300, 8'd7);
        sb.push_back('{4'd0, trace_in[0*MW +: MW]});
        sb.push_back('{4'd3, trace_in[3*MW +: MW]});
        trace_in_valid = 4'b1001;
        @(posedge clk); #1;
        trace_in_valid = '0;
        drain("t2_drain_b");
        chk("t2_count", port_log.size(), 6);
        for (int i = 0; i < 4; i++) chk("t2_rr_order", port_log[i], 4'(i));
        chk("t2_wrap_first",  port_log[4], 4'd0);
        chk("t2_wrap_second", port_log[5], 4'd3);

        // Stall with port 1 pushing six: one in output reg, four buffered, one dropped.
        trace_out_ready = 1'b0;
        for (int i = 0; i < 6; i++)
            push1(1, mk(32'h400 + i, 32'h3000 + 32'(i) * 4, 8'(i + 1)), i < 5);
`ifdef ITM_TRACE_ARBITER_OVERFLOW_MSG_EN
        sb.push_back('{4'd1, mk(32'h0, 32'h0, 8'd1)});
`endif
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            chk("t3_hold_valid", trace_out_valid, 1'b1);
            chk("t3_hold_port",  trace_out_port, 4'd1);
            chk("t3_hold_msg",   trace_out, mk(32'h400, 32'h3000, 8'd1));
        end
        chk("t3_full", fifo_full[1], 1'b1);
        chk("t3_drop", drop_cnt[1*8 +: 8], 8'd1);
        @(posedge clk); #1;
        trace_out_ready = 1'b1;
        drain("t3_drain");
`ifdef ITM_TRACE_ARBITER_OVERFLOW_MSG_EN
        chk("t3_drop_after", drop_cnt[1*8 +: 8], 8'd0);
`else
        chk("t3_drop_after", drop_cnt[1*8 +: 8], 8'd1);
`endif

        // Disabled port 3: strobes ignored even while the sink stalls.
        port_enable     = 4'b0111;
        trace_out_ready = 1'b0;
        for (int i = 0; i < 6; i++) push1(3, mk(32'h500 + i, 32'h4000, 8'd1), 1'b0);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("t4_no_valid", trace_out_valid, 1'b0);
        end
        chk("t4_drop", drop_cnt[3*8 +: 8], 8'd0);
        chk("t4_full", fifo_full[3], 1'b0);
        @(posedge clk); #1;
        port_enable     = '1;
        trace_out_ready = 1'b1;

`ifdef ITM_TRACE_ARBITER_OVERFLOW_MSG_EN
        // Overflow port 0 by three, then drain: marker follows buffered messages.
        trace_out_ready = 1'b0;
        for (int i = 0; i < 8; i++)
            push1(0, mk(32'h600 + i, 32'h5000 + 32'(i) * 4, 8'(i + 1)), i < 5);
        sb.push_back('{4'd0, mk(32'h0, 32'h0, 8'd3)});
        @(negedge clk);
        chk("t5_drop", drop_cnt[0*8 +: 8], 8'd3);
        chk("t5_full", fifo_full[0], 1'b1);
        @(posedge clk); #1;
        trace_out_ready = 1'b1;
        drain("t5_drain");
        chk("t5_drop_clear", drop_cnt[0*8 +: 8], 8'd0);
`endif

        // Asynchronous reset in the middle of a stalled send.
        trace_out_ready = 1'b0;
        push1(0, mk(32'h700, 32'h6000, 8'd2), 1'b0);
        push1(0, mk(32'h701, 32'h6004, 8'd3), 1'b0);
        @(negedge clk);
        chk("t6_pre_valid", trace_out_valid, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_async_valid", trace_out_valid, 1'b0);
        chk("t6_async_out",   trace_out, '0);
        chk("t6_async_drop",  drop_cnt, '0);
        chk("t6_async_full",  fifo_full, '0);
        sb.delete();
        trace_out_ready = 1'b1;
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("t6_empty_valid", trace_out_valid, 1'b0);
        end
        chk("t6_drop_after", drop_cnt, '0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/itm_trace_arbiter.md
Name: itm_trace_arbiter

Overview:
- Shares one trace output link (toward the debug packetizer) between the compressed-trace streams of NUM_PORTS cores.
- Each input is a compressed trace message {timestamp, start address, instruction count} from a per-core ITM trace compression unit. Those units have no backpressure.
- The block buffers each input in a small per-port FIFO, arbitrates round-robin onto a single ready/valid output, and counts dropped messages.

Parameters:
NUM_PORTS, 4, number of trace sources (1..16)
TS_WIDTH, 32, timestamp field width (matches DBG_TIMESTAMP_WIDTH)
CNT_WIDTH, 8, instruction count field width
MSG_WIDTH, TS_WIDTH+32+CNT_WIDTH, message width; layout {ts, addr[31:0], cnt}
FIFO_DEPTH, 4, entries per port FIFO (power of two, >=2)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous reset, active low
port_enable  in  NUM_PORTS  per-port accept enable
trace_in  in  NUM_PORTS*MSG_WIDTH  port p occupies bits [p*MSG_WIDTH +: MSG_WIDTH]
trace_in_valid  in  NUM_PORTS  single-cycle message strobe per port
trace_out  out  MSG_WIDTH  granted message
trace_out_port  out  4  index of source port of trace_out
trace_out_valid  out  1  output message valid
trace_out_ready  in  1  sink accepts when valid&&ready
drop_cnt  out  NUM_PORTS*8  per-port saturating dropped-message counters
fifo_full  out  NUM_PORTS  per-port FIFO full status

Behaviour:
- Reset (rst_n low, asynchronous):
  - trace_out=0, trace_out_port=0, trace_out_valid=0.
  - All FIFOs empty; drop_cnt=0; fifo_full=0.
  - Round-robin pointer = 0.
  - Takes effect immediately even mid-transfer; any held message is lost.
- Input write:
  - trace_in_valid[p] && port_enable[p] && !full[p] pushes the message at the clock edge.
  - If full[p], the message is dropped and drop_cnt[p] increments, saturating at 255.
  - Disabled ports ignore strobes and do not count drops. Their FIFO contents still drain.
- Output register update:
  - Reloads when (!trace_out_valid || trace_out_ready).
  - Candidates are ports with non-empty FIFO. Selection is round-robin starting at rr_ptr: the first non-empty port at or after rr_ptr, wrapping around.
  - Winner's head entry goes to trace_out, its index to trace_out_port, and valid is set to 1. The winner's FIFO pops in the same cycle.
  - rr_ptr = winner+1, wrapping to 0 after NUM_PORTS-1.
  - If no candidate and the register reloads, valid goes to 0. trace_out holds its last value (don't-care).
- State machine, 2 states:
  - IDLE (valid=0): stays while all FIFOs are empty. Moves to SEND on a grant.
  - SEND (valid=1): with ready=0, holds trace_out and trace_out_port stable (no change allowed while valid && !ready).
  - SEND with ready=1: regrants in the same cycle if any candidate exists (sustained 1 msg/cycle); otherwise goes to IDLE.
- Latency and throughput:
  - A message pushed at edge N can appear on trace_out after edge N+1 at the earliest. Minimum 1-cycle FIFO-to-output latency; no combinational input-to-output path.
- Simultaneous push and pop on the same FIFO in one cycle:
  - Both occur; occupancy is unchanged.
  - A push into a full FIFO that is popped the same cycle is accepted, not dropped.
- Ordering: messages from one port leave in arrival order. No ordering is guaranteed across ports.
- fifo_full[p] is registered occupancy == FIFO_DEPTH.

Optional Feature:
ITM_TRACE_ARBITER_OVERFLOW_MSG_EN
- Defined:
  - When drop_cnt[p] != 0, FIFO p has room, and no incoming push to p occurs that cycle, an overflow marker is pushed into FIFO p and drop_cnt[p] clears to 0.
  - Marker = {ts=0, addr=32'h0, cnt=drop count truncated/saturated to CNT_WIDTH}.
  - addr 0 never occurs in real compressed trace, so the marker is unambiguous to the host.
  - An incoming message has priority over marker insertion.
  - If a drop occurs in the same cycle as marker insertion, the counter is set to 1 instead of 0.
- Undefined: no markers are inserted; drop_cnt only increments (saturating) and is cleared only by reset.

Test Plan:
- Reset then single push on port 2 (addr 0x100, cnt 5), ready=1 → trace_out_valid=1 one cycle after the push edge, trace_out_port=2, message intact, then valid=0.
- All 4 ports push one message in the same cycle, ready=1, rr_ptr=0 → outputs in port order 0,1,2,3 on consecutive cycles; next grant starts at port 0.
- ready=0 held 10 cycles with port 1 pushing 6 messages (FIFO_DEPTH=4) → valid stays 1, output stable. Port 1 holds the message loaded into the output register while its FIFO fills; the remaining push(es) overflow, drop_cnt[1] increments per dropped message and fifo_full[1]=1. Order preserved after ready=1.
- port_enable[3]=0 with pushes on port 3 → nothing output, drop_cnt[3]=0.
- With ITM_TRACE_ARBITER_OVERFLOW_MSG_EN, overflow port 0 by 3 messages then drain → marker {ts 0, addr 0, cnt 3} appears after the buffered messages; drop_cnt[0] returns to 0.
- Assert rst_n low mid-SEND with ready=0 → valid drops to 0 immediately (asynchronously); FIFOs empty and counters 0 after release.
